// File: rtl/relax_pkg.sv
// Shared types and constants for the edge-relaxation sequencer.
package relax_pkg;

    localparam int unsigned MAX_NODES_DEFAULT = 37;
    localparam logic [31:0] INF = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StDu,
        StAdj,
        StDv,
        StWr,
        StNext,
        StFin
    } relax_state_e;

    function automatic logic [31:0] row_addr(input logic [31:0] u, input logic [31:0] k,
                                             input int unsigned stride);
        return u * stride + k;
    endfunction

endpackage

// File: rtl/relax_sat_add.sv
// Saturating distance add (clamps at INF) plus signed compare against the stored distance.
module relax_sat_add
    import relax_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] cmp_i,
    output logic [31:0] sum_o,
    output logic        lt_o
);

    logic [32:0] raw;

    assign raw   = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o = (raw >= {1'b0, INF}) ? INF : raw[31:0];
    assign lt_o  = $signed(sum_o) < $signed(cmp_i);

endmodule

// File: rtl/relax_sequencer.sv
// Scans adjacency row u and relaxes dist/path for each neighbour k.
// Optional update counter on relax_cnt_o is built when RELAX_STATS_EN is defined.
module relax_sequencer
    import relax_pkg::*;
#(
    parameter int unsigned MAX_NODES = MAX_NODES_DEFAULT,
    parameter int unsigned W         = 32
) (
    input  logic         clk_50,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] node_u_i,
    input  logic [W-1:0] n_nodes_i,
    output logic [W-1:0] adj_add_o,
    input  logic [W-1:0] adj_output_i,
    output logic         wen_v_o,
    output logic [W-1:0] v_add_o,
    output logic [W-1:0] v_input_o,
    input  logic [W-1:0] v_output_i,
    output logic         wen_path_o,
    output logic [W-1:0] path_add_o,
    output logic [W-1:0] path_input_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [7:0]   relax_cnt_o
);

    relax_state_e state_q, state_d;
    logic [W-1:0] u_q, u_d, n_q, n_d, k_q, k_d, du_q, du_d, w_q, w_d;
    logic [W-1:0] adj_add_q, adj_add_d, v_add_q, v_add_d, v_input_q, v_input_d;
    logic [W-1:0] path_add_q, path_add_d, path_input_q, path_input_d;
    logic         wen_v_q, wen_v_d, wen_path_q, wen_path_d;
    logic         done_q, done_d, err_q, err_d;
    logic [W-1:0] cand;
    logic         improves;

    relax_sat_add u_sat_add (
        .a_i   (du_q),
        .b_i   (w_q),
        .cmp_i (v_output_i),
        .sum_o (cand),
        .lt_o  (improves)
    );

    always_comb begin
        state_d      = state_q;
        u_d          = u_q;
        n_d          = n_q;
        k_d          = k_q;
        du_d         = du_q;
        w_d          = w_q;
        adj_add_d    = adj_add_q;
        v_add_d      = v_add_q;
        v_input_d    = v_input_q;
        path_add_d   = path_add_q;
        path_input_d = path_input_q;
        wen_v_d      = 1'b0;
        wen_path_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    u_d     = node_u_i;
                    n_d     = (n_nodes_i > W'(MAX_NODES)) ? W'(MAX_NODES) : n_nodes_i;
                    v_add_d = node_u_i;
                    state_d = StDu;
                end
            end
            StDu: begin
                du_d = v_output_i;
                if (u_q >= n_q) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (v_output_i == INF || n_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StFin;
                end else begin
                    k_d       = '0;
                    adj_add_d = row_addr(u_q, '0, MAX_NODES);
                    state_d   = StAdj;
                end
            end
            StAdj: begin
                w_d = adj_output_i;
                if (adj_output_i == '0 || k_q == u_q) begin
                    state_d = StNext;
                end else begin
                    v_add_d = k_q;
                    state_d = StDv;
                end
            end
            StDv: begin
                // Strict compare: equal-cost paths keep the first-found predecessor.
                if (improves) begin
                    wen_v_d      = 1'b1;
                    wen_path_d   = 1'b1;
                    v_add_d      = k_q;
                    v_input_d    = cand;
                    path_add_d   = k_q;
                    path_input_d = u_q;
                    state_d      = StWr;
                end else begin
                    state_d = StNext;
                end
            end
            StWr: state_d = StNext;
            StNext: begin
                if (k_q == n_q - W'(1)) begin
                    done_d  = 1'b1;
                    state_d = StFin;
                end else begin
                    k_d       = k_q + W'(1);
                    adj_add_d = row_addr(u_q, k_q + W'(1), MAX_NODES);
                    state_d   = StAdj;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            u_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            du_q         <= '0;
            w_q          <= '0;
            adj_add_q    <= '0;
            v_add_q      <= '0;
            v_input_q    <= '0;
            path_add_q   <= '0;
            path_input_q <= '0;
            wen_v_q      <= 1'b0;
            wen_path_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            u_q          <= u_d;
            n_q          <= n_d;
            k_q          <= k_d;
            du_q         <= du_d;
            w_q          <= w_d;
            adj_add_q    <= adj_add_d;
            v_add_q      <= v_add_d;
            v_input_q    <= v_input_d;
            path_add_q   <= path_add_d;
            path_input_q <= path_input_d;
            wen_v_q      <= wen_v_d;
            wen_path_q   <= wen_path_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign adj_add_o    = adj_add_q;
    assign v_add_o      = v_add_q;
    assign v_input_o    = v_input_q;
    assign wen_v_o      = wen_v_q;
    assign path_add_o   = path_add_q;
    assign path_input_o = path_input_q;
    assign wen_path_o   = wen_path_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != StIdle);

`ifdef RELAX_STATS_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            cnt_q <= '0;
        end else if (state_q == StWr && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign relax_cnt_o = cnt_q;
`else
    assign relax_cnt_o = '0;
`endif

endmodule

// File: tb/tb_relax_sequencer.sv
// Directed bench for relax_sequencer with a negedge-sampled graph RAM model.
module tb_relax_sequencer;

    localparam logic [31:0] INF  = 32'h7FFF_FFFF;
    localparam logic [31:0] DEAD = 32'h0000_DEAD;

    logic        clk_50 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] node_u_i = '0, n_nodes_i = '0;
    logic [31:0] adj_add_o, adj_output_i, v_add_o, v_input_o, v_output_i;
    logic [31:0] path_add_o, path_input_o;
    logic        wen_v_o, wen_path_o, busy_o, done_o, err_o;
    logic [7:0]  relax_cnt_o;

    logic [31:0] adj_mem [0:2047];
    logic [31:0] v_mem   [0:63];
    logic [31:0] path_mem[0:63];
    int          wr_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc;
    logic        err_seen;
    logic [7:0]  exp_cnt;

    always #5 clk_50 = ~clk_50;

    relax_sequencer dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .node_u_i     (node_u_i),
        .n_nodes_i    (n_nodes_i),
        .adj_add_o    (adj_add_o),
        .adj_output_i (adj_output_i),
        .wen_v_o      (wen_v_o),
        .v_add_o      (v_add_o),
        .v_input_o    (v_input_o),
        .v_output_i   (v_output_i),
        .wen_path_o   (wen_path_o),
        .path_add_o   (path_add_o),
        .path_input_o (path_input_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .relax_cnt_o  (relax_cnt_o)
    );

    // RAM: writes land and reads are captured at negedge, with write-through forwarding.
    always @(negedge clk_50) begin
        if (wen_v_o) v_mem[v_add_o[5:0]] <= v_input_o;
        if (wen_path_o) path_mem[path_add_o[5:0]] <= path_input_o;
        if (wen_v_o || wen_path_o) wr_cnt <= wr_cnt + 1;
        v_output_i   <= wen_v_o ? v_input_o : v_mem[v_add_o[5:0]];
        adj_output_i <= adj_mem[adj_add_o[10:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 2048; i++) adj_mem[i] <= '0;
        for (int i = 0; i < 64; i++) begin
            v_mem[i]    <= INF;
            path_mem[i] <= DEAD;
        end
        wr_cnt <= 0;
        #1;
    endtask

    // Cycle 0 is the edge that accepts start; cyc is the edge after which done is seen.
    task automatic run(input logic [31:0] u, input logic [31:0] n, input bit hold,
                       output int cycles, output logic e);
        @(negedge clk_50);
        start_i   = 1'b1;
        node_u_i  = u;
        n_nodes_i = n;
        @(posedge clk_50);
        #1;
        check_eq("busy_after_start", 32'(busy_o), 32'd1);
        if (!hold) start_i = 1'b0;
        cycles = -1;
        e      = 1'b0;
        for (int c = 1; c < 300; c++) begin
            @(posedge clk_50);
            #1;
            if (done_o) begin
                cycles = c;
                e      = err_o;
                break;
            end
        end
        start_i = 1'b0;
        if (cycles < 0) check_eq("done_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk_50);
        #1;
        check_eq("busy_after_done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        init_mem();
        repeat (3) @(posedge clk_50);
        #1;
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_wen", {30'd0, wen_v_o, wen_path_o}, 32'd0);
        check_eq("rst_adj_add", adj_add_o, 32'd0);
        check_eq("rst_v_add", v_add_o, 32'd0);
        check_eq("rst_cnt", 32'(relax_cnt_o), 32'd0);
        @(negedge clk_50);
        rst_n = 1'b1;

        // Basic relaxation: 1 + 74 + 2 edges + 2 updates + 1 FIN -> done at cycle 79.
        init_mem();
        v_mem[0] <= 32'd0; adj_mem[1] <= 32'd3; adj_mem[4] <= 32'd1; #1;
        run(0, 37, 1'b0, cyc, err_seen);
        check_eq("basic_cycles", 32'(cyc), 32'd79);
        check_eq("basic_err", 32'(err_seen), 32'd0);
        check_eq("basic_v1", v_mem[1], 32'd3);
        check_eq("basic_v4", v_mem[4], 32'd1);
        check_eq("basic_p1", path_mem[1], 32'd0);
        check_eq("basic_p4", path_mem[4], 32'd0);
        check_eq("basic_v2", v_mem[2], INF);
        check_eq("basic_writes", 32'(wr_cnt), 32'd2);
`ifdef RELAX_STATS_EN
        exp_cnt = 8'd2;
`else
        exp_cnt = 8'd0;
`endif
        check_eq("basic_cnt", 32'(relax_cnt_o), 32'(exp_cnt));

        // No improvement on column 1 (2 < 3): one update only, done at cycle 78.
        init_mem();
        v_mem[0] <= 32'd0; v_mem[1] <= 32'd2; adj_mem[1] <= 32'd3; adj_mem[4] <= 32'd1; #1;
        run(0, 37, 1'b0, cyc, err_seen);
        check_eq("noimp_cycles", 32'(cyc), 32'd78);
        check_eq("noimp_v1", v_mem[1], 32'd2);
        check_eq("noimp_p1", path_mem[1], DEAD);
        check_eq("noimp_v4", v_mem[4], 32'd1);
`ifdef RELAX_STATS_EN
        exp_cnt = 8'd1;
`else
        exp_cnt = 8'd0;
`endif
        check_eq("noimp_cnt", 32'(relax_cnt_o), 32'(exp_cnt));

        // Equal cost leaves the predecessor untouched.
        init_mem();
        v_mem[0] <= 32'd0; v_mem[1] <= 32'd3; adj_mem[1] <= 32'd3; #1;
        run(0, 37, 1'b0, cyc, err_seen);
        check_eq("equal_p1", path_mem[1], DEAD);
        check_eq("equal_writes", 32'(wr_cnt), 32'd0);

        // Unreached source: DU then FIN.
        init_mem();
        adj_mem[1] <= 32'd3; #1;
        run(0, 37, 1'b0, cyc, err_seen);
        check_eq("unreached_cycles", 32'(cyc), 32'd1);
        check_eq("unreached_writes", 32'(wr_cnt), 32'd0);

        // Bad node.
        init_mem();
        run(40, 37, 1'b0, cyc, err_seen);
        check_eq("badnode_cycles", 32'(cyc), 32'd1);
        check_eq("badnode_err", 32'(err_seen), 32'd1);
        check_eq("badnode_writes", 32'(wr_cnt), 32'd0);

        // Saturation, with n_nodes clamped from 100 to 37: 1 + 74 + 1 edge + 1 -> cycle 76.
        init_mem();
        v_mem[2] <= 32'h7FFF_FFF0; adj_mem[2*37+5] <= 32'h20; #1;
        run(2, 100, 1'b0, cyc, err_seen);
        check_eq("sat_cycles", 32'(cyc), 32'd76);
        check_eq("sat_writes", 32'(wr_cnt), 32'd0);
        check_eq("sat_v5", v_mem[5], INF);

        // Small N: only columns 0..3 of row 1 are scanned, so column 6 is never touched.
        init_mem();
        v_mem[1] <= 32'd10; adj_mem[37+2] <= 32'd5; adj_mem[37+6] <= 32'd1; #1;
        run(1, 4, 1'b0, cyc, err_seen);
        check_eq("smalln_cycles", 32'(cyc), 32'd11);
        check_eq("smalln_v2", v_mem[2], 32'd15);
        check_eq("smalln_p2", path_mem[2], 32'd1);
        check_eq("smalln_v6", v_mem[6], INF);

        // start held high during the whole run must not restart or stretch it.
        init_mem();
        v_mem[0] <= 32'd0; adj_mem[1] <= 32'd3; adj_mem[4] <= 32'd1; #1;
        run(0, 37, 1'b1, cyc, err_seen);
        check_eq("hold_cycles", 32'(cyc), 32'd79);
        check_eq("hold_v1", v_mem[1], 32'd3);

        // Reset while in WR drops the write enables immediately.
        init_mem();
        v_mem[0] <= 32'd0; adj_mem[1] <= 32'd3; #1;
        @(negedge clk_50);
        start_i = 1'b1; node_u_i = 0; n_nodes_i = 37;
        @(posedge clk_50);
        #1;
        start_i = 1'b0;
        cyc = -1;
        for (int c = 1; c < 300; c++) begin
            @(posedge clk_50);
            #1;
            if (wen_v_o) begin
                cyc = c;
                break;
            end
        end
        check_eq("wr_reached", 32'(cyc), 32'd5);
        rst_n = 1'b0;
        #1;
        check_eq("rstwr_wen_v", 32'(wen_v_o), 32'd0);
        check_eq("rstwr_wen_path", 32'(wen_path_o), 32'd0);
        check_eq("rstwr_busy", 32'(busy_o), 32'd0);
        @(negedge clk_50);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_50);
        #1;
        check_eq("rstwr_idle", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/relax_sequencer.md
# relax_sequencer

Edge-relaxation sequencer for the Dijkstra shortest-path engine. Given a current node `u`, it scans row `u` of the adjacency/weight memory and, for every neighbour `k`, reads `dist[k]` from the `v` array. It applies `dist[k] = dist[u] + w`, `path[k] = u` whenever that is strictly shorter. It is the sole master of the `adj`, `v` and `path` ports of the shared graph RAM; the node-selection logic above it issues one `start` per visited node.

## Interface
- `MAX_NODES`, 37: row stride and node-count ceiling.
- `W`, 32: data/address width.
- `clk_50` in 1: single clock, all state updates on posedge; RAM samples on negedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request relaxation; sampled only in IDLE.
- `node_u` in W: current node index.
- `n_nodes` in W: active node count; values above `MAX_NODES` are clamped to `MAX_NODES`.
- `adj_add` out W: adjacency address, `u*MAX_NODES+k`. `adj_output` in W: weight, 0 = no edge.
- `wen_v` out 1, `v_add` out W, `v_input` out W: distance array access. `v_output` in W: signed distance.
- `wen_path` out 1, `path_add` out W, `path_input` out W: predecessor write port.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: one-cycle pulse, coincident with `done`, when `node_u >= n_nodes`.
- `relax_cnt` out 8: updates in the last run (only with the macro).

## Operation
- INF = 32'h7FFF_FFFF. `dist[u] == INF` means `u` is unreached, so there is nothing to relax.
- All RAM address and data outputs are registered and driven from the state being entered.
- States and transitions:
  - IDLE: on `start`, latch `u` and `N` (clamped), drive `v_add=u`, go to DU.
  - DU: capture `du=v_output`. If `u>=N`, go to FIN with `err`. Else if `du==INF` or `N==0`, go to FIN. Else set `k=0`, drive `adj_add`, go to ADJ.
  - ADJ: capture `w=adj_output`. If `w==0` or `k==u`, go to NEXT. Else drive `v_add=k` and go to DV.
  - DV: `cand = du+w`, saturating at INF; a sum ≥ INF yields INF. If `cand < v_output` (signed compare), go to WR; else go to NEXT.
  - WR: one cycle with `wen_v=1`, `v_add=k`, `v_input=cand`, `wen_path=1`, `path_add=k`, `path_input=u`. Then go to NEXT.
  - NEXT: if `k==N-1`, go to FIN; else `k++`, drive `adj_add`, go to ADJ.
  - FIN: `done=1`, then go to IDLE.
- `start` while `busy` is ignored and not queued.
- Equal-cost paths (`cand == dist[k]`) leave `path[k]` unchanged, so the first-found predecessor wins.
- Negative weights are not supported. `w` is treated as unsigned; `w ≥ INF` saturates.

## Timing
- Read latency is 1 cycle: the address registered at posedge t is captured by the RAM at the following negedge, and data is valid at posedge t+1. Data is sampled at the end of the state that drove the address.
- The write issued in WR lands at the mid-cycle negedge, so a read of the same address in the next state returns the new value.
- Per column: 2 cycles for no edge (ADJ, NEXT); 3 cycles for no improvement; 4 cycles for an update.
- Total run cycles = 1 (DU) + 2N + 1·(edges) + 1·(updates) + 1 (FIN).
- Reset values: all address/data outputs 0, `wen_v`=`wen_path`=0, `busy`=`done`=`err`=0, `relax_cnt`=0, state IDLE.
- Reset mid-run forces write enables low immediately. Any WR already committed stays in RAM; there is no rollback.

## Configuration
- `RELAX_STATS_EN`
  - Defined: `relax_cnt` clears on each accepted `start`, increments in each WR, and saturates at 255.
  - Undefined: `relax_cnt` is tied to 0 and the counter logic is absent.

## Structure
- Package `relax_pkg` holds:
  - the state enum (IDLE, DU, ADJ, DV, WR, NEXT, FIN);
  - `INF`;
  - `MAX_NODES` default;
  - the row-address function `u*MAX_NODES+k`.
- One sub-module, `relax_sat_add`: combinational saturating add plus signed less-than. It is instantiated once and unit-testable in isolation.

## Test plan
- Basic relaxation: `v[0]=0`, other `v` = INF, `adj[1]=3`, `adj[4]=1`; start `u=0`, `N=37`. Expect `v[1]=3`, `v[4]=1`, `path[1]=path[4]=0`, and `done` in cycle 79 after the start edge (1 + 74 + 2 + 2 + 1 − 1, counting start edge as cycle 0).
- No improvement: as above with `v[1]=2` preset. Expect `v[1]` unchanged, `path[1]` not written, `v[4]=1`, and `relax_cnt=1` with `RELAX_STATS_EN`.
- Unreached source: `v[u]=INF`. Expect `done` 2 cycles after start, with no `wen_v` or `wen_path` pulse.
- Bad node: `node_u=40`, `N=37`. Expect `done` and `err` in the same cycle, with no writes.
- Saturation: `du=32'h7FFF_FFF0`, `w=32'h20`, `v[k]=INF`. Expect no write.
- Robustness: `start` held high during a run is ignored. Asserting `rst_n=0` while in WR drops `wen_v` and `wen_path` asynchronously and returns the block to IDLE with `busy=0`.
